arbitro_rom: RTL and testbench
==============================

# arbitro_rom

Two-port read arbiter and sequencer for the shared combinational ROM (8-bit address `Dir`, 8-bit data `Dato_s`). It accepts read requests from two independent requesters and grants the ROM to one of them at a time using round-robin priority. It drives the ROM address from a register, captures the ROM output in a register, and returns it with a one-cycle acknowledge pulse. The block sits between datapath clients (for example a fetch unit and a table-lookup unit) and the single ROM instance.

## Interface
Parameters:
- `ANCHO_DIR`, 8: address width; matches ROM `Dir`.
- `ANCHO_DATO`, 8: data width; matches ROM `Dato_s`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `sol0`  in  1  read request, requester 0; level-held until `ack0`.
- `dir0`  in  ANCHO_DIR  read address, requester 0; stable while `sol0` is high.
- `sol1`  in  1  read request, requester 1.
- `dir1`  in  ANCHO_DIR  read address, requester 1.
- `ack0`  out  1  one-cycle pulse: `dato` is valid for requester 0.
- `ack1`  out  1  one-cycle pulse: `dato` is valid for requester 1.
- `dato`  out  ANCHO_DATO  registered read data; shared by both requesters and qualified by `ack0`/`ack1`.
- `ocupado`  out  1  high while a transaction is in progress (state is not REPOSO).
- `num_lecturas`  out  8  count of completed reads; wraps modulo 256.
- `Dir_rom`  out  ANCHO_DIR  address to ROM `Dir`.
- `Dato_rom`  in  ANCHO_DATO  data from ROM `Dato_s` (combinational, same cycle).

## Operation
- FSM states: REPOSO, LEER, ENTREGA.
- **REPOSO**:
  - If neither request is high, stay in REPOSO.
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester selected by priority pointer `prio` (0 or 1).
  - On a grant: latch `dir_reg` ← the granted requester's address, latch `gnt` ← granted index, flip `prio` to the other requester, go to LEER.
- **LEER**: `dato_reg` ← `Dato_rom`, go to ENTREGA.
- **ENTREGA**:
  - Assert `ack[gnt]` for this cycle only.
  - `num_lecturas` increments by 1 (255 → 0).
  - Go to REPOSO.
- `Dir_rom` always equals `dir_reg`. The ROM input changes only when a grant is latched.
- `dato` holds its last value between transactions.
- Requests are sampled only in REPOSO. Changes to `sol`/`dir` during LEER or ENTREGA are ignored.
- If a requester drops `sol` mid-transaction, the transaction still completes and `ack` still pulses; the requester discards it.
- A requester that keeps `sol` high in the cycle after its `ack` issues a new request. Round-robin prevents starvation: under continuous requests from both sides, grants alternate 0, 1, 0, 1.

## Timing
- Reset values: state REPOSO, `prio`=0, `gnt`=0, `dir_reg`=0, `dato_reg`=0, `ack0`=`ack1`=0, `ocupado`=0, `num_lecturas`=0, `Dir_rom`=0, `dato`=0.
- Reset asserted in any state returns to these values on the next edge. An in-flight transaction is abandoned with no `ack`.
- Latency: request seen high at edge N in REPOSO → `ack` high in cycle N+2, with `dato` valid in that same cycle.
- Throughput: one read per 3 cycles. Back-to-back grant: the next request is sampled in the REPOSO cycle after ENTREGA.
- `ack0` and `ack1` are never high together. `ocupado` is high during LEER and ENTREGA.

## Structure
- Shared package `rom_pkg`:
  - state encoding constants `REPOSO`=2'd0, `LEER`=2'd1, `ENTREGA`=2'd2;
  - `ANCHO_DIR`/`ANCHO_DATO` defaults.
- Sub-module `arb_rr2`: two-input round-robin grant logic. Inputs are `sol0`, `sol1`, `prio`; outputs are `gnt_valido` and `gnt_idx`. It is combinational; the pointer register stays in the parent.
- The ROM is instantiated outside the block and connected via `Dir_rom`/`Dato_rom`. The bench instantiates the standard ROM image: dir 0→90, 1→80, 2→40, 3→60, 4→50, 9→100, 10→101, 11→102.

## Test plan
- Reset check: hold `rst` high for 2 cycles, then release → all outputs 0, state REPOSO, `num_lecturas`=0.
- Single read: `sol0`=1, `dir0`=3 → `ack0` pulses exactly 2 cycles after sampling with `dato`=60; `ack1` stays 0; `num_lecturas`=1.
- Simultaneous requests: `sol0`/`sol1` both high, `dir0`=0, `dir1`=9, held continuously → first `ack0` with `dato`=90, then `ack1` with 100, then `ack0` with 90; each `ack` is 3 cycles after the previous one.
- Request drop: `sol1`=1, `dir1`=11, then `sol1` driven to 0 during LEER → `ack1` still pulses with `dato`=102; the FSM returns to REPOSO and no further grant is issued.
- Mid-operation reset: grant `dir0`=2, then assert `rst` during LEER → no `ack`, `ocupado`=0, `dato`=0, `prio`=0.
- Counter wrap: 256 consecutive reads of `dir0`=4 → `dato`=50 on every `ack`, and `num_lecturas` wraps 255 → 0 on the 256th read.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM read arbiter: FSM state encoding and
// default address/data widths matching the ROM instance.
package rom_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    LEER    = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  localparam int ANCHO_DIR_DEF  = 8;
  localparam int ANCHO_DATO_DEF = 8;

endpackage : rom_pkg

// File: rtl/arb_rr2.sv
// Two-input round-robin grant logic. Purely combinational; the priority
// pointer lives in the parent so it only moves when a grant is latched.
module arb_rr2 (
  input  logic sol0,
  input  logic sol1,
  input  logic prio,
  output logic gnt_valido,
  output logic gnt_idx
);

  // A lone request wins outright; a tie goes to the requester the pointer names.
  always_comb begin
    gnt_valido = sol0 | sol1;
    if (sol0 && sol1) begin
      gnt_idx = prio;
    end else begin
      gnt_idx = sol1;
    end
  end

endmodule : arb_rr2

// File: rtl/arbitro_rom.sv
// Round-robin read arbiter/sequencer in front of the shared combinational ROM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// REPOSO  | idle; requests sampled, grant latches address/index, flips prio
// LEER    | ROM address stable; capture ROM output into the data register
// ENTREGA | ack pulse to the granted requester, read counter increments
module arbitro_rom
  import rom_pkg::*;
#(
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sol0,
  input  logic [ANCHO_DIR-1:0]  dir0,
  input  logic                  sol1,
  input  logic [ANCHO_DIR-1:0]  dir1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [ANCHO_DATO-1:0] dato,
  output logic                  ocupado,
  output logic [7:0]            num_lecturas,
  output logic [ANCHO_DIR-1:0]  Dir_rom,
  input  logic [ANCHO_DATO-1:0] Dato_rom
);

  estado_t               estado_q, estado_d;
  logic                  prio_q, prio_d;
  logic                  gnt_q, gnt_d;
  logic [ANCHO_DIR-1:0]  dir_q, dir_d;
  logic [ANCHO_DATO-1:0] dato_q, dato_d;
  logic [7:0]            cnt_q, cnt_d;

  logic gnt_valido;
  logic gnt_idx;

  arb_rr2 u_arb (
    .sol0       (sol0),
    .sol1       (sol1),
    .prio       (prio_q),
    .gnt_valido (gnt_valido),
    .gnt_idx    (gnt_idx)
  );

  // State and datapath registers; reset abandons any in-flight read silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
      prio_q   <= 1'b0;
      gnt_q    <= 1'b0;
      dir_q    <= '0;
      dato_q   <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and register updates; requests are only looked at in REPOSO.
  always_comb begin
    estado_d = estado_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    dir_d    = dir_q;
    dato_d   = dato_q;
    cnt_d    = cnt_q;
    unique case (estado_q)
      REPOSO: begin
        if (gnt_valido) begin
          gnt_d    = gnt_idx;
          dir_d    = gnt_idx ? dir1 : dir0;
          prio_d   = ~gnt_idx;
          estado_d = LEER;
        end
      end
      LEER: begin
        dato_d   = Dato_rom;
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        cnt_d    = cnt_q + 8'd1;
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // Outputs decode straight from registers so they are glitch-free.
  always_comb begin
    ack0         = (estado_q == ENTREGA) && !gnt_q;
    ack1         = (estado_q == ENTREGA) &&  gnt_q;
    ocupado      = (estado_q != REPOSO);
    dato         = dato_q;
    num_lecturas = cnt_q;
    Dir_rom      = dir_q;
  end

endmodule : arbitro_rom

// File: tb/tb_arbitro_rom.sv
// Directed bench for arbitro_rom: a per-cycle vector table covering reset,
// single read, round-robin tie, request drop and mid-read reset, followed by
// a hand-written 256-read counter wrap sequence.
module tb_arbitro_rom;

  logic       clk = 1'b0;
  logic       rst;
  logic       sol0, sol1;
  logic [7:0] dir0, dir1;
  logic       ack0, ack1, ocupado;
  logic [7:0] dato, num_lecturas, Dir_rom;
  logic [7:0] Dato_rom;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Standard ROM image; unlisted addresses read as zero.
  always_comb begin
    case (Dir_rom)
      8'd0:    Dato_rom = 8'd90;
      8'd1:    Dato_rom = 8'd80;
      8'd2:    Dato_rom = 8'd40;
      8'd3:    Dato_rom = 8'd60;
      8'd4:    Dato_rom = 8'd50;
      8'd9:    Dato_rom = 8'd100;
      8'd10:   Dato_rom = 8'd101;
      8'd11:   Dato_rom = 8'd102;
      default: Dato_rom = 8'd0;
    endcase
  end

  arbitro_rom dut (
    .clk          (clk),
    .rst          (rst),
    .sol0         (sol0),
    .dir0         (dir0),
    .sol1         (sol1),
    .dir1         (dir1),
    .ack0         (ack0),
    .ack1         (ack1),
    .dato         (dato),
    .ocupado      (ocupado),
    .num_lecturas (num_lecturas),
    .Dir_rom      (Dir_rom),
    .Dato_rom     (Dato_rom)
  );

  typedef struct {
    logic       rst;
    logic       s0;
    logic [7:0] d0;
    logic       s1;
    logic [7:0] d1;
    logic       a0;
    logic       a1;
    logic       oc;
    logic [7:0] dat;
    logic [7:0] num;
    logic [7:0] dir;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic r, input logic s0, input logic [7:0] d0,
                     input logic s1, input logic [7:0] d1,
                     input logic a0, input logic a1, input logic oc,
                     input logic [7:0] dat, input logic [7:0] num, input logic [7:0] dir);
    vec_t v;
    v.rst = r; v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1;
    v.a0 = a0; v.a1 = a1; v.oc = oc; v.dat = dat; v.num = num; v.dir = dir;
    tbl.push_back(v);
  endtask

  int k;

  initial begin
    rst = 1'b1; sol0 = 1'b0; sol1 = 1'b0; dir0 = '0; dir1 = '0;

    //    rst s0 d0  s1 d1  | a0 a1 oc dato num dir   (outputs after the edge)
    // reset held 2 cycles, then idle
    add(1, 0, 0,  0, 0,    0, 0, 0, 0,   0, 0);
    add(1, 0, 0,  0, 0,    0, 0, 0, 0,   0, 0);
    add(0, 0, 0,  0, 0,    0, 0, 0, 0,   0, 0);
    // single read of address 3
    add(0, 1, 3,  0, 0,    0, 0, 1, 0,   0, 3);
    add(0, 1, 3,  0, 0,    1, 0, 1, 60,  0, 3);
    add(0, 0, 3,  0, 0,    0, 0, 0, 60,  1, 3);
    // reset to bring prio back to 0, then continuous tie 0/9
    add(1, 0, 0,  0, 0,    0, 0, 0, 0,   0, 0);
    add(0, 1, 0,  1, 9,    0, 0, 1, 0,   0, 0);
    add(0, 1, 0,  1, 9,    1, 0, 1, 90,  0, 0);
    add(0, 1, 0,  1, 9,    0, 0, 0, 90,  1, 0);
    add(0, 1, 0,  1, 9,    0, 0, 1, 90,  1, 9);
    add(0, 1, 0,  1, 9,    0, 1, 1, 100, 1, 9);
    add(0, 1, 0,  1, 9,    0, 0, 0, 100, 2, 9);
    add(0, 1, 0,  1, 9,    0, 0, 1, 100, 2, 0);
    add(0, 1, 0,  1, 9,    1, 0, 1, 90,  2, 0);
    add(0, 0, 0,  0, 9,    0, 0, 0, 90,  3, 0);
    add(0, 0, 0,  0, 9,    0, 0, 0, 90,  3, 0);
    // requester 1 drops its request during LEER
    add(0, 0, 0,  1, 11,   0, 0, 1, 90,  3, 11);
    add(0, 0, 0,  0, 11,   0, 1, 1, 102, 3, 11);
    add(0, 0, 0,  0, 11,   0, 0, 0, 102, 4, 11);
    add(0, 0, 0,  0, 11,   0, 0, 0, 102, 4, 11);
    // reset during LEER abandons the read
    add(0, 1, 2,  0, 0,    0, 0, 1, 102, 4, 2);
    add(1, 1, 2,  0, 0,    0, 0, 0, 0,   0, 0);
    add(0, 0, 2,  0, 0,    0, 0, 0, 0,   0, 0);
    // tie after reset goes to requester 0 (prio cleared)
    add(0, 1, 1,  1, 10,   0, 0, 1, 0,   0, 1);
    add(0, 0, 1,  0, 10,   1, 0, 1, 80,  0, 1);
    add(0, 0, 1,  0, 10,   0, 0, 0, 80,  1, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; sol0 = tbl[i].s0; dir0 = tbl[i].d0;
      sol1 = tbl[i].s1; dir1 = tbl[i].d1;
      @(posedge clk); #1;
      chk($sformatf("v%0d ack0", i),    32'(ack0),         32'(tbl[i].a0));
      chk($sformatf("v%0d ack1", i),    32'(ack1),         32'(tbl[i].a1));
      chk($sformatf("v%0d ocupado", i), 32'(ocupado),      32'(tbl[i].oc));
      chk($sformatf("v%0d dato", i),    32'(dato),         32'(tbl[i].dat));
      chk($sformatf("v%0d num", i),     32'(num_lecturas), 32'(tbl[i].num));
      chk($sformatf("v%0d Dir_rom", i), 32'(Dir_rom),      32'(tbl[i].dir));
    end

    // Counter wrap: 256 back-to-back reads of address 4 from requester 0.
    rst = 1'b1; sol0 = 1'b0; sol1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; sol0 = 1'b1; dir0 = 8'd4;
    k = 0;
    for (int c = 0; c < 2000 && k < 256; c++) begin
      @(posedge clk); #1;
      chk("wrap ack1", 32'(ack1), 32'd0);
      if (ack0) begin
        k++;
        chk($sformatf("wrap dato #%0d", k), 32'(dato), 32'd50);
        chk($sformatf("wrap num #%0d", k), 32'(num_lecturas), 32'((k - 1) & 255));
        if (k == 256) sol0 = 1'b0;
      end
    end
    chk("wrap ack count", 32'(k), 32'd256);
    @(posedge clk); #1;
    chk("wrap num after 256", 32'(num_lecturas), 32'd0);
    chk("wrap ocupado end", 32'(ocupado), 32'd0);
    @(posedge clk); #1;
    chk("wrap no regrant", 32'(ocupado), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_arbitro_rom
